// File: rtl/memory_ram_loader_if.sv
// memory_ram_loader_if
//   Bundles the loader's stream input, status and read-port signals.
//   The slave modport is the loader itself, and the master modport is whoever
//   drives it (a bench or an upstream block).
//
//   Signals:
//     start, in_valid, in_ready, in_data  load stream and handshake
//     busy, done, wr_count, checksum      load-pass status
//     en, address, out                    synchronous read port (1-cycle latency)
//     par_err, inject_err                 only when MEM_LOADER_PARITY_EN is defined
interface memory_ram_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic [DATA_W-1:0] checksum;
  logic              en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] out;
`ifdef MEM_LOADER_PARITY_EN
  logic              par_err;
  logic              inject_err;

  modport slave (
    input  start, in_valid, in_data, en, address, inject_err,
    output in_ready, busy, done, wr_count, checksum, out, par_err
  );

  modport master (
    output start, in_valid, in_data, en, address, inject_err,
    input  in_ready, busy, done, wr_count, checksum, out, par_err
  );
`else
  modport slave (
    input  start, in_valid, in_data, en, address,
    output in_ready, busy, done, wr_count, checksum, out
  );

  modport master (
    output start, in_valid, in_data, en, address,
    input  in_ready, busy, done, wr_count, checksum, out
  );
`endif
endinterface

// File: rtl/memory_ram_loader.sv
// memory_ram_loader
//   This is the writer side of the memory read path. It accepts a valid/ready
//   stream of DATA_W-bit words and writes them into a DEPTH-entry RAM at
//   addresses 0..DEPTH-1. It also keeps a running checksum of the loaded image.
//   The read port matches the ROM core's timing: when en=1 at a rising edge,
//   out is loaded with mem[address] one cycle later. When en=0, out holds.
//
//   Ports:
//     clk  single clock, rising edge
//     rst  asynchronous active-high reset. It does not clear the RAM contents.
//     bus  memory_ram_loader_if.slave (stream, status and read port)
//
//   Optional feature:
//     MEM_LOADER_PARITY_EN  Each RAM word stores an even-parity bit. The
//                           par_err output flags a mismatch on read, and the
//                           inject_err input inverts the stored bit.
module memory_ram_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_ram_loader_if.slave   bus
);

`ifdef MEM_LOADER_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] out_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  wr_word;
  logic              wr_fire;

  // A word transfers whenever the FSM is in LOAD and the source is valid.
  // in_ready is high for exactly that state.
  assign wr_fire = (state_q == S_LOAD) && bus.in_valid;

`ifdef MEM_LOADER_PARITY_EN
  // XOR of the data gives the even-parity bit. inject_err flips the stored bit.
  assign wr_word = {(^bus.in_data) ^ bus.inject_err, bus.in_data};
`else
  assign wr_word = bus.in_data;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: if (wr_fire && (wr_count_q == LAST_CNT)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // Pass counters. wr_count also serves as the write pointer, because the
  // FSM leaves LOAD before the pointer can go past DEPTH-1.
  always_comb begin
    wr_count_d = wr_count_q;
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && bus.start) begin
      wr_count_d = '0;
      checksum_d = '0;
    end else if (wr_fire) begin
      wr_count_d = wr_count_q + 1'b1;
      checksum_d = checksum_q + bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
      checksum_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
    end
  end

  // RAM write port. The RAM has no reset, so an image loaded before a reset
  // is still there afterwards.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_count_q[ADDR_W-1:0]] <= wr_word;
  end

  // Registered read port. A read and a write to the same address on the same
  // edge return the old word (read-first).
`ifdef MEM_LOADER_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      par_err_q <= 1'b0;
    end else if (bus.en) begin
      out_q     <= mem_q[bus.address][DATA_W-1:0];
      par_err_q <= ^mem_q[bus.address];
    end
  end

  assign bus.par_err = par_err_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_q <= '0;
    else if (bus.en) out_q <= mem_q[bus.address];
  end
`endif

  assign bus.wr_count = wr_count_q;
  assign bus.checksum = checksum_q;
  assign bus.out      = out_q;

endmodule

// File: tb/tb_memory_ram_loader.sv
// tb_memory_ram_loader
//   Directed bench for memory_ram_loader. Expected values are computed by hand
//   from the stimulus.
module tb_memory_ram_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done;
  int   exp_cnt;

  always #5 clk = ~clk;

  memory_ram_loader_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  memory_ram_loader #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle 1ns past it. The bench drives and
  // samples at this point, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    bus.en      = 1'b1;
    bus.address = a;
    tick();
    bus.en      = 1'b0;
    check(tag, {16'h0, bus.out}, {16'h0, exp});
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.en       = 1'b0;
    bus.address  = '0;
`ifdef MEM_LOADER_PARITY_EN
    bus.inject_err = 1'b0;
`endif

    // 1. Reset, then stay idle
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("rst_busy",     {31'h0, bus.busy},     32'h0);
    check("rst_done",     {31'h0, bus.done},     32'h0);
    check("rst_wr_count", {27'h0, bus.wr_count}, 32'h0);
    check("rst_checksum", {16'h0, bus.checksum}, 32'h0);
    check("rst_out",      {16'h0, bus.out},      32'h0);
`ifdef MEM_LOADER_PARITY_EN
    check("rst_par_err",  {31'h0, bus.par_err},  32'h0);
`endif

    // 2. Full load of 16'h1000+i, with in_valid held high
    start_pass();
    check("load_ready",   {31'h0, bus.in_ready}, 32'h1);
    check("load_busy",    {31'h0, bus.busy},     32'h1);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1000 + 16'(i);
      tick();
      check($sformatf("full_cnt%0d", i), {27'h0, bus.wr_count}, 32'(i + 1));
    end
    bus.in_valid = 1'b0;
    check("full_done",     {31'h0, bus.done},     32'h1);
    check("full_busy_off", {31'h0, bus.busy},     32'h0);
    check("full_ready_off",{31'h0, bus.in_ready}, 32'h0);
    check("full_checksum", {16'h0, bus.checksum}, 32'h0078);
    // A start raised during DONE is ignored.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_pulse_end",{31'h0, bus.done},     32'h0);
    check("done_start_ign",{31'h0, bus.busy},     32'h0);
    tick();
    check("idle_stays",    {31'h0, bus.busy},     32'h0);
    check("hold_count",    {27'h0, bus.wr_count}, 32'd16);
    check("hold_checksum", {16'h0, bus.checksum}, 32'h0078);
    for (int a = 0; a < 16; a++)
      read_chk($sformatf("full_rd%0d", a), 4'(a), 16'h1000 + 16'(a));
    // With en low, out keeps its last value.
    bus.address = 4'd3;
    tick();
    check("en_low_hold", {16'h0, bus.out}, 32'h100F);

    // 3. Back-pressure: in_valid alternates over 32 cycles
    start_pass();
    n_done  = 0;
    exp_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = 16'h2000 + 16'(c / 2);
      bus.start    = (c == 10);   // start is ignored while in LOAD
      tick();
      if (c % 2 == 0) exp_cnt++;
      if (bus.done) n_done++;
      check($sformatf("bp_cnt%0d", c), {27'h0, bus.wr_count}, 32'(exp_cnt));
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    tick();
    check("bp_done_once", 32'(n_done), 32'd1);
    // 16'h2000+...+16'h200F = 0x20000 + 0x78, which truncates to 0x0078.
    check("bp_checksum", {16'h0, bus.checksum}, 32'h0078);
    for (int a = 0; a < 16; a++)
      read_chk($sformatf("bp_rd%0d", a), 4'(a), 16'h2000 + 16'(a));

    // 4. Read-first collision at address 5
    start_pass();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 5) ? 16'hAAAA : 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    start_pass();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 5) ? 16'h5555 : 16'h3000 + 16'(i);
      bus.en       = (i == 5);
      bus.address  = 4'd5;
      tick();
      bus.en = 1'b0;
      if (i == 5) check("rf_old", {16'h0, bus.out}, 32'hAAAA);
    end
    bus.in_valid = 1'b0;
    tick();
    read_chk("rf_new", 4'd5, 16'h5555);

    // 5. Reset in the middle of a load
    start_pass();
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h4000 + 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_cnt7", {27'h0, bus.wr_count}, 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_cnt",   {27'h0, bus.wr_count}, 32'h0);
    check("mid_rst_busy",  {31'h0, bus.busy},     32'h0);
    check("mid_rst_ready", {31'h0, bus.in_ready}, 32'h0);
    check("mid_rst_csum",  {16'h0, bus.checksum}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    read_chk("mid_keep0", 4'd0, 16'h4000);
    read_chk("mid_keep6", 4'd6, 16'h4006);
    read_chk("mid_keep7", 4'd7, 16'h3007);
    start_pass();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      tick();
    end
    bus.in_valid = 1'b0;
    check("ff_done",     {31'h0, bus.done},     32'h1);
    check("ff_checksum", {16'h0, bus.checksum}, 32'hFFF0);
    for (int a = 0; a < 16; a++)
      read_chk($sformatf("ff_rd%0d", a), 4'(a), 16'hFFFF);

`ifdef MEM_LOADER_PARITY_EN
    // 6. Inject a parity fault on address 3
    start_pass();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_data    = 16'h0101 * 16'(i);
      bus.inject_err = (i == 3);
      tick();
    end
    bus.in_valid   = 1'b0;
    bus.inject_err = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      bus.en      = 1'b1;
      bus.address = 4'(a);
      tick();
      bus.en = 1'b0;
      check($sformatf("par_rd%0d", a), {16'h0, bus.out}, 32'(16'h0101 * 16'(a)));
      check($sformatf("par_err%0d", a), {31'h0, bus.par_err}, (a == 3) ? 32'h1 : 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
